// File: rtl/opentdc_pkg.sv
// Shared register map, bit positions and the Wishbone FSM state type for the
// TDC event FIFO.
package opentdc_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    localparam logic [31:0] EMPTY_MARKER = 32'hFFFF_FFFF;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_LEVEL_LSB = 15;
    localparam int ST_OVF       = 22;
    localparam int ST_DROP_LSB  = 24;

    localparam int CT_FLUSH      = 0;
    localparam int CT_IRQ_EN     = 1;
    localparam int CT_THRESH_LSB = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } wb_state_t;

    function automatic logic [31:0] pack_status(input logic [7:0] drops,
                                                input logic       ovf,
                                                input logic [6:0] lvl,
                                                input logic       emp,
                                                input logic       ful);
        logic [31:0] s;
        s = '0;
        s[ST_DROP_LSB +: 8]  = drops;
        s[ST_OVF]            = ovf;
        s[ST_LEVEL_LSB +: 7] = lvl;
        s[ST_EMPTY]          = emp;
        s[ST_FULL]           = ful;
        return s;
    endfunction

    function automatic logic [31:0] pack_ctrl(input logic [5:0] thresh,
                                              input logic       irq_en);
        logic [31:0] c;
        c = '0;
        c[CT_THRESH_LSB +: 6] = thresh;
        c[CT_IRQ_EN]          = irq_en;
        return c;
    endfunction

endpackage

// File: rtl/opentdc_evfifo_mem.sv
// Event storage: one synchronous write port, one combinational read port.
// Contents are never reset; validity is tracked by the pointers in the top.
module opentdc_evfifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/opentdc_evfifo.sv
// TDC event FIFO with a Wishbone register window: queues {channel, timestamp}
// records, counts drops on overflow and raises a level interrupt.
module opentdc_evfifo
    import opentdc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CH_W  = 4,
    parameter int TS_W  = 28
) (
    input  logic            wb_clk_i,
    input  logic            rst_n_i,
    input  logic            ev_valid_i,
    input  logic [CH_W-1:0] ev_chan_i,
    input  logic [TS_W-1:0] ev_ts_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            irq_o
);

    localparam int AW = $clog2(DEPTH);

    wb_state_t   state, state_nxt;
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic [6:0]  level7;
    logic        empty, full;
    logic [31:0] mem_rdata, rdata_nxt;
    logic [1:0]  reg_sel;
    logic        access, rd_acc, wr_acc;
    logic        pop, push, drop, flush, clear, ctrl_wr;
    logic [7:0]  drop_cnt;
    logic        ovf, irq_en;
    logic [5:0]  thresh, thresh_eff;
    logic        unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:8]};

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    assign level  = wr_ptr - rd_ptr;
    assign level7 = 7'(level);
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // ACK always returns to IDLE, so a held strobe is acked every other cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (wbs_stb_i && wbs_cyc_i) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wbs_ack_o = (state == S_ACK);

    assign reg_sel = wbs_adr_i[3:2];
    assign access  = (state == S_IDLE) && wbs_stb_i && wbs_cyc_i;
    assign rd_acc  = access && !wbs_we_i;
    assign wr_acc  = access && wbs_we_i;

    assign pop     = rd_acc && (reg_sel == REG_DATA) && !empty;
    assign ctrl_wr = wr_acc && (reg_sel == REG_CTRL) && wbs_sel_i[0];
    assign flush   = ctrl_wr && wbs_dat_i[CT_FLUSH];
    assign clear   = wr_acc && (reg_sel == REG_CLEAR);
    // A pop frees the slot the same cycle, so a full FIFO still accepts then.
    assign push    = ev_valid_i && !flush && (!full || pop);
    assign drop    = ev_valid_i && !flush && full && !pop;

    always_comb begin
        rdata_nxt = '0;
        case (reg_sel)
            REG_DATA:   rdata_nxt = empty ? EMPTY_MARKER : mem_rdata;
            REG_STATUS: rdata_nxt = pack_status(drop_cnt, ovf, level7, empty, full);
            REG_CTRL:   rdata_nxt = pack_ctrl(thresh, irq_en);
            default:    rdata_nxt = '0;
        endcase
    end

    assign thresh_eff = (thresh == 6'd0) ? 6'd1 : thresh;

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
            irq_en    <= 1'b0;
            thresh    <= 6'd1;
            wbs_dat_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            if (clear) begin
                drop_cnt <= '0;
                ovf      <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end

            if (ctrl_wr) begin
                thresh <= wbs_dat_i[CT_THRESH_LSB +: 6];
                irq_en <= wbs_dat_i[CT_IRQ_EN];
            end

            if (rd_acc) wbs_dat_o <= rdata_nxt;

            irq_o <= irq_en && (level7 >= {1'b0, thresh_eff});
        end
    end

    opentdc_evfifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (CH_W + TS_W)
    ) u_mem (
        .clk   (wb_clk_i),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({ev_chan_i, ev_ts_i}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_opentdc_evfifo.sv
// Directed bench for opentdc_evfifo: a vector table for basic traffic plus
// hand-written sequences for overflow, flush, irq and reset corner cases.
module tb_opentdc_evfifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ev_valid = 1'b0;
    logic [3:0]  ev_chan = '0;
    logic [27:0] ev_ts = '0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] wdat = '0, adr = 32'h3000_0100;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opentdc_evfifo #(.DEPTH(DEPTH), .CH_W(4), .TS_W(28)) dut (
        .wb_clk_i   (clk),
        .rst_n_i    (rst_n),
        .ev_valid_i (ev_valid),
        .ev_chan_i  (ev_chan),
        .ev_ts_i    (ev_ts),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (wdat),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .irq_o      (irq)
    );

    typedef struct {
        int          op;   // 0 push, 1 read+check, 2 write
        logic [1:0]  reg_idx;
        logic [31:0] wd;
        logic [3:0]  ch;
        logic [27:0] ts;
        logic [31:0] exp;
    } vec_t;

    vec_t tab [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [3:0] ch, input logic [27:0] ts);
        ev_valid = 1'b1; ev_chan = ch; ev_ts = ts;
        tick();
        ev_valid = 1'b0;
    endtask

    // One full access: request edge (ack registered) then the ack cycle.
    task automatic wb(input logic w, input logic [1:0] r, input logic [31:0] d,
                      input logic [3:0] s, input logic ev, input logic [3:0] ch,
                      input logic [27:0] ts, output logic [31:0] q);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; wdat = d;
        adr = 32'h3000_0100 | {28'd0, r, 2'b00};
        ev_valid = ev; ev_chan = ch; ev_ts = ts;
        tick();
        ev_valid = 1'b0;
        chk("ack", {31'd0, ack}, 32'd1);
        q = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] q);
        wb(1'b0, r, 32'd0, 4'hF, 1'b0, 4'd0, 28'd0, q);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] q;
        wb(1'b1, r, d, 4'hF, 1'b0, 4'd0, 28'd0, q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] q;
        int acks;

        tab[0]  = '{1, 2'd1, 32'd0, 4'd0, 28'd0,  32'h0000_0002};
        tab[1]  = '{1, 2'd2, 32'd0, 4'd0, 28'd0,  32'h0000_0004};
        tab[2]  = '{1, 2'd3, 32'd0, 4'd0, 28'd0,  32'h0000_0000};
        tab[3]  = '{0, 2'd0, 32'd0, 4'd1, 28'd10, 32'd0};
        tab[4]  = '{0, 2'd0, 32'd0, 4'd2, 28'd20, 32'd0};
        tab[5]  = '{0, 2'd0, 32'd0, 4'd3, 28'd30, 32'd0};
        tab[6]  = '{1, 2'd1, 32'd0, 4'd0, 28'd0,  32'h0001_8000};
        tab[7]  = '{1, 2'd0, 32'd0, 4'd0, 28'd0,  32'h1000_000A};
        tab[8]  = '{1, 2'd0, 32'd0, 4'd0, 28'd0,  32'h2000_0014};
        tab[9]  = '{1, 2'd0, 32'd0, 4'd0, 28'd0,  32'h3000_001E};
        tab[10] = '{1, 2'd0, 32'd0, 4'd0, 28'd0,  32'hFFFF_FFFF};
        tab[11] = '{1, 2'd1, 32'd0, 4'd0, 28'd0,  32'h0000_0002};

        tick(); tick();
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_dat", rdat, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic traffic from the vector table
        for (int i = 0; i < 12; i++) begin
            case (tab[i].op)
                0: push(tab[i].ch, tab[i].ts);
                1: begin
                    rd(tab[i].reg_idx, q);
                    chk($sformatf("vec%0d", i), q, tab[i].exp);
                end
                default: wr(tab[i].reg_idx, tab[i].wd);
            endcase
        end

        // Overflow: DEPTH+5 pushes, 5 drops
        for (int i = 0; i < DEPTH + 5; i++) push(4'(i), 28'(100 + i));
        rd(2'd1, q);
        chk("ovf_status", q, 32'h0548_0001);
        for (int i = 0; i < DEPTH; i++) begin
            rd(2'd0, q);
            chk($sformatf("ovf_data%0d", i), q, {4'(i), 28'(100 + i)});
        end

        // Flush with a concurrent event: not queued, not counted as a drop
        for (int i = 0; i < 5; i++) push(4'd7, 28'(i));
        wb(1'b1, 2'd2, 32'h0000_0001, 4'hF, 1'b1, 4'd9, 28'd999, q);
        rd(2'd1, q);
        chk("flush_status", q, 32'h0540_0002);
        rd(2'd0, q);
        chk("flush_data", q, 32'hFFFF_FFFF);
        rd(2'd2, q);
        chk("flush_ctrl", q, 32'h0000_0000);
        wr(2'd3, 32'd0);
        rd(2'd1, q);
        chk("clear_status", q, 32'h0000_0002);

        // Push coinciding with a pop on a full FIFO
        for (int i = 0; i < DEPTH; i++) push(4'hA, 28'(200 + i));
        wb(1'b0, 2'd0, 32'd0, 4'hF, 1'b1, 4'hF, 28'h0AB_CDEF, q);
        chk("fullpop_data", q, {4'hA, 28'd200});
        rd(2'd1, q);
        chk("fullpop_status", q, 32'h0008_0001);
        for (int i = 1; i < DEPTH; i++) begin
            rd(2'd0, q);
            chk($sformatf("fullpop_d%0d", i), q, {4'hA, 28'(200 + i)});
        end
        rd(2'd0, q);
        chk("fullpop_last", q, 32'hF0AB_CDEF);

        // Interrupt threshold
        wr(2'd2, 32'h0000_000E);
        rd(2'd2, q);
        chk("ctrl_rb", q, 32'h0000_000E);
        push(4'd5, 28'd1);
        push(4'd5, 28'd2);
        chk("irq_lvl2", {31'd0, irq}, 32'd0);
        push(4'd5, 28'd3);
        chk("irq_lvl3_same", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_rise", {31'd0, irq}, 32'd1);
        rd(2'd0, q);
        chk("irq_pop_data", q, 32'h5000_0001);
        chk("irq_fall", {31'd0, irq}, 32'd0);
        wb(1'b1, 2'd2, 32'h0000_00FF, 4'hE, 1'b0, 4'd0, 28'd0, q);
        rd(2'd2, q);
        chk("ctrl_sel_ignored", q, 32'h0000_000E);
        wr(2'd2, 32'h0000_0002);
        chk("irq_thresh0", {31'd0, irq}, 32'd1);
        rd(2'd0, q);
        chk("irq_d2", q, 32'h5000_0002);
        rd(2'd0, q);
        chk("irq_d3", q, 32'h5000_0003);
        chk("irq_empty", {31'd0, irq}, 32'd0);

        // A held strobe is acked every other cycle
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0104;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        tick();
        chk("held_stb_acks", 32'(acks), 32'd2);

        // Reset during a Wishbone read
        for (int i = 0; i < 4; i++) push(4'd6, 28'(i));
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0100;
        rst_n = 1'b0;
        tick();
        chk("rst_no_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1; stb = 1'b0; cyc = 1'b0;
        tick();
        rd(2'd1, q);
        chk("rst_status", q, 32'h0000_0002);
        rd(2'd0, q);
        chk("rst_data", q, 32'hFFFF_FFFF);
        rd(2'd2, q);
        chk("rst_ctrl", q, 32'h0000_0004);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
